// File: rtl/booth_dpath.sv
// Radix-2 Booth multiplier datapath: working registers, status to the controller, and a product output register with a valid/ready handshake.
// Optional overrun flag is enabled by defining BOOTH_DPATH_OVR_EN.
module booth_dpath #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 clr,
    input  logic                 ld,
    input  logic                 add_sub,
    input  logic                 shft,
    input  logic                 done,
    output logic                 cmp,
    output logic                 incr,
    output logic [2*WIDTH-1:0]   product,
    output logic                 product_valid,
    input  logic                 product_ready,
    output logic                 ovr
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH:0]   a;
    logic [WIDTH-1:0] q;
    logic             qm1;
    logic [WIDTH:0]   m;
    logic [CW-1:0]    count;
    logic             handshake;

    assign cmp       = q[0] ^ qm1;
    assign incr      = (count > CW'(1));
    assign handshake = product_valid && product_ready;

    // A and M carry one guard bit so that -2^(WIDTH-1) operands cannot overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a     <= '0;
            q     <= '0;
            qm1   <= 1'b0;
            m     <= '0;
            count <= '0;
        end else if (clr) begin
            a     <= '0;
            q     <= '0;
            qm1   <= 1'b0;
            m     <= '0;
            count <= '0;
        end else if (ld) begin
            a     <= '0;
            q     <= multiplier;
            qm1   <= 1'b0;
            m     <= {multiplicand[WIDTH-1], multiplicand};
            count <= CW'(WIDTH);
        end else if (add_sub) begin
            case ({q[0], qm1})
                2'b10:   a <= a - m;
                2'b01:   a <= a + m;
                default: a <= a;
            endcase
        end else if (shft) begin
            {a, q, qm1} <= {a[WIDTH], a, q};
            count       <= (count == '0) ? '0 : count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            product       <= '0;
            product_valid <= 1'b0;
        end else if (done) begin
            product       <= {a[WIDTH-1:0], q};
            product_valid <= 1'b1;
        end else if (handshake) begin
            product_valid <= 1'b0;
        end
    end

`ifdef BOOTH_DPATH_OVR_EN
    logic overrun;

    // An overrun is a new product replacing one the consumer never accepted.
    assign overrun = done && product_valid && !product_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovr <= 1'b0;
        end else if (clr) begin
            ovr <= 1'b0;
        end else if (overrun) begin
            ovr <= 1'b1;
        end
    end
`else
    assign ovr = 1'b0;
`endif

endmodule

// File: tb/tb_booth_dpath.sv
// Directed testbench for booth_dpath: drives the strobe sequence a Booth controller would issue
// and compares outputs against hand-computed products.
module tb_booth_dpath;

    localparam int WIDTH = 8;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 clr;
    logic                 ld;
    logic                 add_sub;
    logic                 shft;
    logic                 done;
    logic                 cmp;
    logic                 incr;
    logic [2*WIDTH-1:0]   product;
    logic                 product_valid;
    logic                 product_ready;
    logic                 ovr;

    int errors = 0;
    int checks = 0;
    logic exp_ovr;

    always #5 clk = ~clk;

    booth_dpath #(.WIDTH(WIDTH)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .multiplicand  (multiplicand),
        .multiplier    (multiplier),
        .clr           (clr),
        .ld            (ld),
        .add_sub       (add_sub),
        .shft          (shft),
        .done          (done),
        .cmp           (cmp),
        .incr          (incr),
        .product       (product),
        .product_valid (product_valid),
        .product_ready (product_ready),
        .ovr           (ovr)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Load, then WIDTH add_sub/shft iterations; optionally stacks add_sub+shft on the load cycle.
    task automatic applyStimulus(input logic [7:0] mc, input logic [7:0] mp, input bit combine_ld, input bit check_incr);
        multiplicand = mc;
        multiplier   = mp;
        ld           = 1'b1;
        if (combine_ld) begin
            add_sub = 1'b1;
            shft    = 1'b1;
        end
        tick;
        ld      = 1'b0;
        add_sub = 1'b0;
        shft    = 1'b0;
        checkOutput("cmp_after_ld", 32'(cmp), 32'(mp[0]));
        if (combine_ld) checkOutput("count_after_ld_combo", 32'(dut.count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            add_sub = 1'b1;
            tick;
            add_sub = 1'b0;
            shft    = 1'b1;
            if (check_incr) checkOutput($sformatf("incr_shift%0d", i), 32'(incr), (i < 7) ? 32'd1 : 32'd0);
            tick;
            shft = 1'b0;
        end
    endtask

    task automatic pulse_done(input bit ready);
        done          = 1'b1;
        product_ready = ready;
        tick;
        done          = 1'b0;
        product_ready = 1'b0;
    endtask

    task automatic consume(input string tag);
        product_ready = 1'b1;
        tick;
        product_ready = 1'b0;
        checkOutput({tag, "_valid_after_accept"}, 32'(product_valid), 32'd0);
    endtask

    task automatic run_and_check(input string tag, input logic [7:0] mc, input logic [7:0] mp, input logic [15:0] expected);
        applyStimulus(mc, mp, 1'b0, 1'b0);
        pulse_done(1'b0);
        checkOutput({tag, "_valid"}, 32'(product_valid), 32'd1);
        checkOutput({tag, "_product"}, 32'(product), 32'(expected));
        consume(tag);
    endtask

    initial begin
        reset_n       = 1'b0;
        multiplicand  = '0;
        multiplier    = '0;
        clr           = 1'b0;
        ld            = 1'b0;
        add_sub       = 1'b0;
        shft          = 1'b0;
        done          = 1'b0;
        product_ready = 1'b0;
`ifdef BOOTH_DPATH_OVR_EN
        exp_ovr = 1'b1;
`else
        exp_ovr = 1'b0;
`endif
        tick;
        tick;
        reset_n = 1'b1;
        tick;
        checkOutput("rst_product", 32'(product), 32'd0);
        checkOutput("rst_valid", 32'(product_valid), 32'd0);
        checkOutput("rst_cmp", 32'(cmp), 32'd0);
        checkOutput("rst_incr", 32'(incr), 32'd0);
        checkOutput("rst_ovr", 32'(ovr), 32'd0);

        // 3 * -4 with incr tracking, then saturation of the counter
        applyStimulus(8'd3, 8'hFC, 1'b0, 1'b1);
        checkOutput("count_after_8_shifts", 32'(dut.count), 32'd0);
        pulse_done(1'b0);
        checkOutput("m3q-4_valid", 32'(product_valid), 32'd1);
        checkOutput("m3q-4_product", 32'(product), 32'hFFF4);
        shft = 1'b1;
        tick;
        shft = 1'b0;
        checkOutput("count_saturated", 32'(dut.count), 32'd0);
        checkOutput("incr_saturated", 32'(incr), 32'd0);
        checkOutput("product_stable", 32'(product), 32'hFFF4);
        consume("m3q-4");

        run_and_check("m-128q-128", 8'h80, 8'h80, 16'h4000);
        run_and_check("m127q127", 8'h7F, 8'h7F, 16'h3F01);
        run_and_check("m0q-1", 8'h00, 8'hFF, 16'h0000);

        // Overrun: second done while the first product is still unaccepted
        applyStimulus(8'd5, 8'd5, 1'b0, 1'b0);
        pulse_done(1'b0);
        checkOutput("ovr_first_product", 32'(product), 32'h0019);
        applyStimulus(8'd2, 8'd3, 1'b0, 1'b0);
        pulse_done(1'b0);
        checkOutput("ovr_product", 32'(product), 32'h0006);
        checkOutput("ovr_valid", 32'(product_valid), 32'd1);
        checkOutput("ovr_flag", 32'(ovr), 32'(exp_ovr));
        clr = 1'b1;
        tick;
        clr = 1'b0;
        checkOutput("ovr_after_clr", 32'(ovr), 32'd0);
        checkOutput("valid_after_clr", 32'(product_valid), 32'd1);
        checkOutput("product_after_clr", 32'(product), 32'h0006);

        // done coincident with the accepting handshake is not an overrun
        applyStimulus(8'd4, 8'd4, 1'b0, 1'b0);
        pulse_done(1'b1);
        checkOutput("hs_done_product", 32'(product), 32'h0010);
        checkOutput("hs_done_valid", 32'(product_valid), 32'd1);
        checkOutput("hs_done_ovr", 32'(ovr), 32'd0);

        // Asynchronous reset in the 4th iteration with a product still pending
        multiplicand = 8'd3;
        multiplier   = 8'hFC;
        ld = 1'b1;
        tick;
        ld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            add_sub = 1'b1;
            tick;
            add_sub = 1'b0;
            shft = 1'b1;
            tick;
            shft = 1'b0;
        end
        add_sub = 1'b1;
        tick;
        add_sub = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_product", 32'(product), 32'd0);
        checkOutput("midrst_valid", 32'(product_valid), 32'd0);
        checkOutput("midrst_cmp", 32'(cmp), 32'd0);
        checkOutput("midrst_incr", 32'(incr), 32'd0);
        checkOutput("midrst_ovr", 32'(ovr), 32'd0);
        tick;
        reset_n = 1'b1;
        tick;
        checkOutput("postrst_valid", 32'(product_valid), 32'd0);
        clr = 1'b1;
        tick;
        clr = 1'b0;
        run_and_check("m7q-2", 8'd7, 8'hFE, 16'hFFF2);

        // ld with add_sub and shft in the same cycle: only the load counts
        applyStimulus(8'd3, 8'hFC, 1'b1, 1'b0);
        pulse_done(1'b0);
        checkOutput("combo_product", 32'(product), 32'hFFF4);
        consume("combo");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
